// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one step per clock).
// Optional invalid-digit checking is enabled by defining BCD_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  valid,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_reg;
  logic [WORK_W-1:0]   work_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;
  logic                valid_reg;
  logic [BIN_W-1:0]    bin_out_reg;

  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   corrected;
  logic [BIN_W-1:0]    result_next;
  logic                last_step;

  assign shifted = work_reg >> 1;
  assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];

  // After the shift, any digit that became >= 8 held an odd tens carry; take back 3.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_correct
      assign corrected[BIN_W+4*gi +: 4] = shifted[BIN_W+4*gi+3]
                                          ? shifted[BIN_W+4*gi +: 4] - 4'd3
                                          : shifted[BIN_W+4*gi +: 4];
    end
  endgenerate

  assign last_step = (cnt_reg == CNT_W'(BIN_W - 1));

`ifdef BCD_CHECK_EN
  logic [DIGITS-1:0] digit_bad;
  logic              err_pend_reg;
  logic              err_reg;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_check
      assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign result_next = err_pend_reg ? '0 : corrected[BIN_W-1:0];
  assign err         = err_reg;
`else
  assign result_next = corrected[BIN_W-1:0];
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      work_reg    <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      bin_out_reg <= '0;
`ifdef BCD_CHECK_EN
      err_pend_reg <= 1'b0;
      err_reg      <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        // DONE accepts a new request exactly like IDLE, giving back-to-back throughput.
        IDLE, DONE: begin
          if (start) begin
            work_reg  <= {bcd_in, {BIN_W{1'b0}}};
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
`ifdef BCD_CHECK_EN
            err_pend_reg <= |digit_bad;
            err_reg      <= 1'b0;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          work_reg <= corrected;
          cnt_reg  <= cnt_reg + 1'b1;
          if (last_step) begin
            bin_out_reg <= result_next;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b1;
            state_reg   <= DONE;
`ifdef BCD_CHECK_EN
            err_reg <= err_pend_reg;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign valid   = valid_reg;
  assign bin_out = bin_out_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: cycle-level reference model plus directed literal checks.
// Exercises the BCD_CHECK_EN error path when that macro is defined.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
`ifdef BCD_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                valid;
  logic [BIN_W-1:0]    bin_out;
  logic                err;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .valid   (valid),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int bcd_val(input logic [4*DIGITS-1:0] b);
    int v = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += int'(b[4*i +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic bit has_bad(input logic [4*DIGITS-1:0] b);
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4*DIGITS-1:0] rand_bcd();
    logic [4*DIGITS-1:0] b;
    for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  // Reference model: a request accepted while idle completes BIN_W edges later.
  bit               m_busy, m_valid, m_err, m_err_pend, m_acc;
  logic [BIN_W-1:0] m_bin, m_pend;
  int               edge_n, done_at, n_results;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_err = 0; m_err_pend = 0;
      m_bin = '0; m_pend = '0; edge_n = 0; done_at = 0;
    end else begin
      m_acc = !m_busy && (start === 1'b1);
      edge_n++;
      m_valid = 0;
      if (m_busy && edge_n == done_at) begin
        m_busy  = 0;
        m_valid = 1;
        m_bin   = (CHECK && m_err_pend) ? '0 : m_pend;
        m_err   = CHECK && m_err_pend;
        n_results++;
      end
      if (m_acc) begin
        m_busy     = 1;
        done_at    = edge_n + BIN_W;
        m_pend     = BIN_W'(bcd_val(bcd_in));
        m_err_pend = has_bad(bcd_in);
        m_err      = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_busy",    32'(busy),    32'(m_busy));
    chk("model_valid",   32'(valid),   32'(m_valid));
    chk("model_bin_out", 32'(bin_out), 32'(m_bin));
    chk("model_err",     32'(err),     32'(m_err));
  end

  // Called at +1 after an edge; the request is sampled on the following edge.
  task automatic issue(input logic [4*DIGITS-1:0] b);
    #1;
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_bin, input bit exp_err);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) break;
    end
    chk({name, "_valid_seen"}, 32'(valid), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'(BIN_W));
    chk({name, "_bin_out"}, 32'(bin_out), 32'(exp_bin));
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    $display("conv %s: bin_out=%0d err=%0b edges_after_accept=%0d", name, bin_out, err, n);
  endtask

  int nv;

  initial begin
    rst_n = 1'b0; start = 1'b0; bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_bin_out", 32'(bin_out), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(16'h1234);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_result("h1234", 1234, 1'b0);

    // Async reset part-way through a conversion.
    issue(16'h5678);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_bin_out", 32'(bin_out), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    nv = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
    chk("no_valid_after_reset", 32'(nv), 32'd0);
    $display("reset mid-conversion: valid pulses afterwards=%0d", nv);

    issue(16'h9999);
    wait_result("h9999", 9999, 1'b0);
    issue(16'h0000);
    wait_result("h0000", 0, 1'b0);
    issue(16'h0321);
    wait_result("h0321", 321, 1'b0);
    // Back-to-back: request presented during the DONE cycle.
    issue(16'h0042);
    chk("b2b_hold_prev", 32'(bin_out), 32'd321);
    wait_result("h0042_b2b", 42, 1'b0);

`ifdef BCD_CHECK_EN
    issue(16'h12A4);
    wait_result("h12A4_bad", 0, 1'b1);
    issue(16'h0007);
    wait_result("h0007_after_bad", 7, 1'b0);
`endif

    // Start held high, bcd_in churning every cycle.
    #1 start = 1'b1;
    bcd_in = rand_bcd();
    nv = 0;
    repeat (46) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
      #1 bcd_in = rand_bcd();
    end
    start = 1'b0;
    chk("held_start_valid_count", 32'(nv), 32'd3);
    $display("start held high 46 edges: valid pulses=%0d", nv);
    repeat (20) @(posedge clk);

    // Random traffic: random start pattern, random digits, invalid ones only when checked.
    n_results = 0;
    repeat (800) begin
      @(posedge clk);
      #2;
      start  = ($urandom_range(0, 3) == 0);
      bcd_in = rand_bcd();
      if (CHECK && $urandom_range(0, 7) == 0) bcd_in = 16'($urandom);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    chk("random_activity", 32'(n_results > 20), 32'd1);
    $display("random phase: results=%0d", n_results);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
